// File: rtl/acc_dump.sv
// Block accumulator: sums signed samples in blocks of a programmable length and
// dumps each saturated block sum as a one-cycle pulse, with restart via sync.
module acc_dump #(
    parameter int DIN_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        sync,
    input  logic [LEN_WIDTH-1:0]        dump_len,
    input  logic                        din_valid,
    input  logic signed [DIN_WIDTH-1:0] din,
    output logic signed [ACC_WIDTH-1:0] dout,
    output logic                        dout_valid,
    output logic                        dout_sat
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                        r_state;
    state_t                        w_next;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic [LEN_WIDTH-1:0]          r_cnt;
    logic                          r_sticky;
    logic [LEN_WIDTH-1:0]          r_len;
    logic signed [ACC_WIDTH-1:0]   r_dout;
    logic                          r_doutValid;
    logic                          r_doutSat;

    logic                          w_run;
    logic                          w_load;
    logic                          w_accept;
    logic                          w_last;
    logic [LEN_WIDTH-1:0]          w_lenIn;
    logic [LEN_WIDTH-1:0]          w_lenCur;
    logic signed [ACC_WIDTH-1:0]   w_accBase;
    logic [LEN_WIDTH-1:0]          w_cntBase;
    logic                          w_stickyBase;
    logic signed [ACC_WIDTH:0]     w_sumWide;
    logic                          w_clamp;
    logic signed [ACC_WIDTH-1:0]   w_sumSat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (en)  w_next = RUN;
            RUN:     if (!en) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_run    = (r_state == RUN) && en;
        w_load   = ((r_state == IDLE) && en) || (w_run && sync);
        w_accept = w_run && din_valid;
    end

    // A sync restarts the block this cycle, so the sample arriving with it is
    // counted against the freshly presented length rather than the old one.
    always_comb begin
        w_lenIn      = (dump_len == '0) ? LEN_WIDTH'(1) : dump_len;
        w_lenCur     = (w_run && sync) ? w_lenIn : r_len;
        w_accBase    = (w_run && !sync) ? r_acc : '0;
        w_cntBase    = (w_run && !sync) ? r_cnt : '0;
        w_stickyBase = w_run && !sync && r_sticky;
        w_sumWide    = (ACC_WIDTH+1)'(w_accBase) + (ACC_WIDTH+1)'(din);
        w_clamp      = w_sumWide[ACC_WIDTH] != w_sumWide[ACC_WIDTH-1];
        if (w_clamp) begin
            w_sumSat = w_sumWide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            w_sumSat = w_sumWide[ACC_WIDTH-1:0];
        end
        w_last = w_accept && ((w_cntBase + LEN_WIDTH'(1)) == w_lenCur);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sticky    <= 1'b0;
            r_len       <= LEN_WIDTH'(1);
            r_dout      <= '0;
            r_doutValid <= 1'b0;
            r_doutSat   <= 1'b0;
        end else begin
            r_doutValid <= 1'b0;
            if (w_load) begin
                r_len <= w_lenIn;
            end
            if (!w_run) begin
                r_acc    <= '0;
                r_cnt    <= '0;
                r_sticky <= 1'b0;
            end else if (w_last) begin
                r_acc       <= '0;
                r_cnt       <= '0;
                r_sticky    <= 1'b0;
                r_dout      <= w_sumSat;
                r_doutSat   <= w_stickyBase || w_clamp;
                r_doutValid <= 1'b1;
                r_len       <= w_lenIn;
            end else if (w_accept) begin
                r_acc    <= w_sumSat;
                r_cnt    <= w_cntBase + LEN_WIDTH'(1);
                r_sticky <= w_stickyBase || w_clamp;
            end else begin
                r_acc    <= w_accBase;
                r_cnt    <= w_cntBase;
                r_sticky <= w_stickyBase;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_doutValid;
    assign dout_sat   = r_doutSat;

endmodule

// File: doc/acc_dump.md
ACC_DUMP -- requirements
Module: acc_dump

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 16: signed input sample width.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: signed accumulator/output width; legal range DIN_WIDTH+1 to 48.
REQ-003 SHALL have parameter LEN_WIDTH, default 8: width of block-length control.
REQ-004 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  block enable; low forces IDLE.
REQ-007 SHALL have port sync  input  1  single-cycle restart of block boundary.
REQ-008 SHALL have port dump_len  input  LEN_WIDTH  samples per block (value 0 treated as 1).
REQ-009 SHALL have port din_valid  input  1  din qualifier.
REQ-010 SHALL have port din  input  DIN_WIDTH  signed two's-complement sample.
REQ-011 SHALL have port dout  output  ACC_WIDTH  signed block sum, feeds downstream rounding stage.
REQ-012 SHALL have port dout_valid  output  1  one-cycle pulse qualifying dout.
REQ-013 SHALL have port dout_sat  output  1  high with dout_valid when the block sum clamped.

Function
REQ-014 SHALL implement FSM states IDLE and RUN; IDLE->RUN when en=1; RUN->IDLE when en=0 (partial sum discarded, no output).
REQ-015 SHALL latch dump_len into an internal length register on IDLE->RUN entry, on sync, and on the cycle after each dump; changes at other times are ignored.
REQ-016 SHALL, in RUN with din_valid=1, add sign-extended din to accumulator and increment sample counter; din_valid=0 holds both.
REQ-017 SHALL saturate each addition to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and set an internal sticky flag for the block on clamp; clamped value is the new accumulator.
REQ-018 SHALL, on acceptance of sample number L (latched length), present the final sum (including that sample) on dout with dout_valid=1 exactly one cycle later.
REQ-019 SHALL clear accumulator, counter and sticky flag in the same cycle the last sample is accepted, so the next cycle's sample begins a new block with no gap.
REQ-020 SHALL hold dout and dout_sat at the last dumped value when dout_valid=0.
REQ-021 SHALL, on sync=1 in RUN, discard the partial block; if din_valid=1 in the same cycle, that sample becomes sample 1 of the new block; sync on what would be the final sample suppresses the dump.
REQ-022 SHALL ignore sync and din_valid in IDLE; en=0 overrides sync.
REQ-023 SHALL support L=1: every accepted sample produces a dout_valid one cycle later with dout = din sign-extended.
REQ-024 SHALL sustain one accepted sample per clock indefinitely; counter wraps only via the dump rule, never overflows.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, accumulator 0, counter 0, sticky 0, length register 1, dout 0, dout_valid 0, dout_sat 0.
REQ-026 SHALL, on rst asserted mid-block, abandon the block with no dout_valid; after release, operation starts from IDLE.

Verification
REQ-027 SHALL verify basic dump: en=1, dump_len=4, din 1,2,3,4 on consecutive cycles -> dout=10, dout_valid one cycle after the 4th sample, dout_sat=0.
REQ-028 SHALL verify back-to-back blocks: dump_len=2, continuous din=-5 for 6 cycles -> three dout_valid pulses, each dout=-10, spaced 2 cycles apart.
REQ-029 SHALL verify gaps and sync: dump_len=3, din 7, (gap), 7, sync with din=1, then 1,1 -> single dout=3; the 7s never appear.
REQ-030 SHALL verify saturation with ACC_WIDTH=17, DIN_WIDTH=16: dump_len=3, din=32767 x3 -> dout=65535, dout_sat=1; next block din=-32768 x3 -> dout=-65536, dout_sat=1.
REQ-031 SHALL verify L=1 and dump_len=0: each din 100,-1 -> dout 100,-1 on successive cycles, one pulse per sample.
REQ-032 SHALL verify reset/en abort: dump_len=4, 3 samples then rst pulse (or en=0) -> no dout_valid, dout=0 after rst; next 4 samples of 2 -> dout=8.
